// File: rtl/window_5x5_former_pkg.sv
// window_5x5_former_pkg: shared canny constants, types and window index helper
package window_5x5_former_pkg;
  localparam int WIDTH_DEF = 320;
  localparam int HEIGHT_DEF = 240;
  localparam int PIX_W = 8;
  localparam int KSIZE = 5;
  localparam int COORD_W = 9;
  localparam int WIN_W = PIX_W * KSIZE * KSIZE;
  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [COORD_W-1:0] coord_t;
  function automatic int win_idx(input int r, input int c);
    return KSIZE * r + c;
  endfunction
endpackage

// File: rtl/window_5x5_former_if.sv
// window_5x5_former_if: pixel taps in, registered 5x5 window and coordinates out
interface window_5x5_former_if;
  import window_5x5_former_pkg::*;
  logic ld;
  logic sof;
  pix_t tap0;
  pix_t tap1;
  pix_t tap2;
  pix_t tap3;
  pix_t tap4;
  logic [WIN_W-1:0] win;
  logic win_vld;
  coord_t win_row;
  coord_t win_col;
  logic frame_done;
  modport master (
    output ld, sof, tap0, tap1, tap2, tap3, tap4,
    input win, win_vld, win_row, win_col, frame_done
  );
  modport slave (
    input ld, sof, tap0, tap1, tap2, tap3, tap4,
    output win, win_vld, win_row, win_col, frame_done
  );
endinterface

// File: rtl/window_5x5_former_raster_counter.sv
// raster_counter: col/row position of the arriving pixel with wrap, sof resync and interior/last flags
module raster_counter
  import window_5x5_former_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int HEIGHT = HEIGHT_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   adv_i,
  input  logic   sof_i,
  output coord_t col_o,
  output coord_t row_o,
  output logic   interior_o,
  output logic   last_o
);
  localparam coord_t COL_MAX = coord_t'(WIDTH - 1);
  localparam coord_t ROW_MAX = coord_t'(HEIGHT - 1);
  localparam coord_t EDGE = coord_t'(KSIZE - 1);
  coord_t col_q, row_q, col_d, row_d;
  assign col_o = sof_i ? '0 : col_q;
  assign row_o = sof_i ? '0 : row_q;
  assign interior_o = row_o >= EDGE && col_o >= EDGE;
  assign last_o = row_o == ROW_MAX && col_o == COL_MAX;
  // step to the position of the following pixel whenever one is consumed
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (adv_i) begin
      col_d = col_o == COL_MAX ? '0 : col_o + 1'b1;
      row_d = col_o != COL_MAX ? row_o : row_o == ROW_MAX ? '0 : row_o + 1'b1;
    end
  end
  // position registers, cleared by the active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end
endmodule

// File: rtl/window_5x5_former.sv
// window_5x5_former: shifts line-buffer taps into a 5x5 window and emits interior windows with centre coordinates
module window_5x5_former
  import window_5x5_former_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int HEIGHT = HEIGHT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  window_5x5_former_if.slave    bus
);
  localparam coord_t HALF = coord_t'(KSIZE / 2);
  logic ld_q, sof_q, vld_q, fd_q;
  logic [WIN_W-1:0] win_q, win_d;
  coord_t row_q, col_q, cur_row, cur_col;
  logic interior, last;
  pix_t tap [KSIZE];
  assign tap[0] = bus.tap0;
  assign tap[1] = bus.tap1;
  assign tap[2] = bus.tap2;
  assign tap[3] = bus.tap3;
  assign tap[4] = bus.tap4;
  raster_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .adv_i      (ld_q),
    .sof_i      (sof_q),
    .col_o      (cur_col),
    .row_o      (cur_row),
    .interior_o (interior),
    .last_o     (last)
  );
  for (genvar r = 0; r < KSIZE; r++) begin : g_row
    for (genvar c = 0; c < KSIZE; c++) begin : g_col
      if (c == KSIZE - 1) begin : g_new
        assign win_d[PIX_W*win_idx(r, c) +: PIX_W] = tap[r];
      end else begin : g_old
        assign win_d[PIX_W*win_idx(r, c) +: PIX_W] = win_q[PIX_W*win_idx(r, c + 1) +: PIX_W];
      end
    end
  end
  // align ld with the taps, shift the window and register validity/coordinates of the arriving pixel
  always_ff @(posedge clk) begin
    if (!rst) begin
      ld_q  <= 1'b0;
      sof_q <= 1'b0;
      vld_q <= 1'b0;
      fd_q  <= 1'b0;
      win_q <= '0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      ld_q  <= bus.ld;
      sof_q <= bus.ld & bus.sof;
      vld_q <= ld_q & interior;
      fd_q  <= ld_q & interior & last;
      if (ld_q) win_q <= win_d;
      if (ld_q && interior) begin
        row_q <= cur_row - HALF;
        col_q <= cur_col - HALF;
      end
    end
  end
  assign bus.win = win_q;
  assign bus.win_vld = vld_q;
  assign bus.win_row = row_q;
  assign bus.win_col = col_q;
  assign bus.frame_done = fd_q;
endmodule
